// File: rtl/stbuf_bus_bridge_if.sv
// Signal bundle linking store_buffer, stbuf_bus_bridge and the word-aligned memory port.
// slave is the bridge's view; master is the view of the surrounding store_buffer + memory.
interface stbuf_bus_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] stbuf_bus_read_addr;
  logic [SIZE_WIDTH-1:0] stbuf_bus_read_size;
  logic                  stbuf_bus_read_req;
  logic [ADDR_WIDTH-1:0] stbuf_bus_write_addr;
  logic [SIZE_WIDTH-1:0] stbuf_bus_write_size;
  logic [DATA_WIDTH-1:0] stbuf_bus_data;
  logic                  stbuf_bus_write_req;
  logic [DATA_WIDTH-1:0] bus_stbuf_data;
  logic                  bus_stbuf_read_ack;
  logic                  bus_stbuf_write_ack;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_req;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  stbuf_bus_read_addr, stbuf_bus_read_size, stbuf_bus_read_req,
           stbuf_bus_write_addr, stbuf_bus_write_size, stbuf_bus_data, stbuf_bus_write_req,
           mem_gnt, mem_rvalid, mem_rdata,
    output bus_stbuf_data, bus_stbuf_read_ack, bus_stbuf_write_ack,
           mem_addr, mem_wr, mem_wdata, mem_wstrb, mem_req
  );

  modport master (
    output stbuf_bus_read_addr, stbuf_bus_read_size, stbuf_bus_read_req,
           stbuf_bus_write_addr, stbuf_bus_write_size, stbuf_bus_data, stbuf_bus_write_req,
           mem_gnt, mem_rvalid, mem_rdata,
    input  bus_stbuf_data, bus_stbuf_read_ack, bus_stbuf_write_ack,
           mem_addr, mem_wr, mem_wdata, mem_wstrb, mem_req
  );
endinterface

// File: rtl/stbuf_bus_bridge.sv
// Arbitrates store_buffer load misses and store drains onto one word-aligned req/gnt/rvalid
// memory port, splitting word-crossing accesses into two beats and right-justifying read data.
module stbuf_bus_bridge #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SIZE_WIDTH   = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  stbuf_bus_bridge_if.slave bus
);
  localparam int unsigned STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RWAIT,
    ST_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]              off_q, off_d;
  logic [SIZE_WIDTH-1:0]   size_q, size_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    is_write_q, is_write_d;
  logic                    two_beats_q, two_beats_d;
  logic                    illegal_q, illegal_d;
  logic                    beat_q, beat_d;
  logic [STARVE_WIDTH-1:0] starve_q, starve_d;

  // Arbitration and request decode.
  logic                  read_pend, write_pend, pick_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [SIZE_WIDTH-1:0] sel_size;
  logic                  sel_size_ok;
  logic [SIZE_WIDTH:0]   sel_span;

  always_comb begin
    read_pend   = bus.stbuf_bus_read_req;
    write_pend  = bus.stbuf_bus_write_req;
    pick_write  = write_pend && (!read_pend || (starve_q == STARVE_MAX));
    sel_addr    = pick_write ? bus.stbuf_bus_write_addr : bus.stbuf_bus_read_addr;
    sel_size    = pick_write ? bus.stbuf_bus_write_size : bus.stbuf_bus_read_size;
    sel_size_ok = (sel_size == SIZE_WIDTH'(1)) || (sel_size == SIZE_WIDTH'(2)) ||
                  (sel_size == SIZE_WIDTH'(4));
    sel_span    = {{(SIZE_WIDTH-1){1'b0}}, sel_addr[1:0]} + {1'b0, sel_size};
  end

  // Lane geometry of the latched access.
  logic [3:0]            size_mask;
  logic [7:0]            strb_wide;
  logic [3:0]            strb_lo, strb_hi;
  logic [4:0]            lo_shamt;
  logic [5:0]            hi_shamt;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    case (size_q)
      SIZE_WIDTH'(1): begin
        size_mask = 4'b0001;
        keep_mask = {{(DATA_WIDTH-8){1'b0}}, 8'hff};
      end
      SIZE_WIDTH'(2): begin
        size_mask = 4'b0011;
        keep_mask = {{(DATA_WIDTH-16){1'b0}}, 16'hffff};
      end
      default: begin
        size_mask = 4'b1111;
        keep_mask = '1;
      end
    endcase
    lo_shamt  = {off_q, 3'b000};
    hi_shamt  = 6'(DATA_WIDTH) - {1'b0, off_q, 3'b000};
    strb_wide = {4'b0000, size_mask} << off_q;
    strb_lo   = strb_wide[3:0];
    strb_hi   = size_mask >> (3'd4 - {1'b0, off_q});
    // Beat 0 starts a fresh result; beat 1 supplies the upper bytes above the beat-0 tail.
    if (!beat_q) begin
      merged = bus.mem_rdata >> lo_shamt;
    end else begin
      merged = rdata_q | (bus.mem_rdata << hi_shamt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Illegal sizes still pass through REQ (with mem_req held low) so the ack lands one
  // cycle later, matching the timing store_buffer expects for any rejected request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (read_pend || write_pend) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (illegal_q) begin
          state_d = ST_DONE;
        end else if (bus.mem_gnt) begin
          if (!is_write_q) begin
            state_d = ST_RWAIT;
          end else if (!(two_beats_q && !beat_q)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RWAIT: begin
        if (bus.mem_rvalid) begin
          state_d = (two_beats_q && !beat_q) ? ST_REQ : ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    off_d       = off_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    is_write_d  = is_write_q;
    two_beats_d = two_beats_q;
    illegal_d   = illegal_q;
    beat_d      = beat_q;
    starve_d    = starve_q;
    case (state_q)
      ST_IDLE: begin
        if (read_pend || write_pend) begin
          addr_d      = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
          off_d       = sel_addr[1:0];
          size_d      = sel_size;
          wdata_d     = bus.stbuf_bus_data;
          rdata_d     = '0;
          is_write_d  = pick_write;
          two_beats_d = sel_span > (SIZE_WIDTH+1)'(4);
          illegal_d   = !sel_size_ok;
          beat_d      = 1'b0;
          if (pick_write) begin
            starve_d = '0;
          end else if (write_pend && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_WIDTH'(1);
          end
        end
      end
      ST_REQ: begin
        if (!illegal_q && bus.mem_gnt && is_write_q && two_beats_q && !beat_q) begin
          beat_d = 1'b1;
        end
      end
      ST_RWAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = merged & keep_mask;
          if (two_beats_q && !beat_q) begin
            beat_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      off_q       <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      is_write_q  <= 1'b0;
      two_beats_q <= 1'b0;
      illegal_q   <= 1'b0;
      beat_q      <= 1'b0;
      starve_q    <= '0;
    end else begin
      addr_q      <= addr_d;
      off_q       <= off_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      is_write_q  <= is_write_d;
      two_beats_q <= two_beats_d;
      illegal_q   <= illegal_d;
      beat_q      <= beat_d;
      starve_q    <= starve_d;
    end
  end

  // Gating on rst drops mem_req in the very cycle reset is asserted.
  always_comb begin
    bus.mem_req             = 1'b0;
    bus.mem_wr              = 1'b0;
    bus.mem_addr            = '0;
    bus.mem_wdata           = '0;
    bus.mem_wstrb           = '0;
    bus.bus_stbuf_read_ack  = 1'b0;
    bus.bus_stbuf_write_ack = 1'b0;
    bus.bus_stbuf_data      = rdata_q;
    if (!rst) begin
      case (state_q)
        ST_REQ: begin
          if (!illegal_q) begin
            bus.mem_req  = 1'b1;
            bus.mem_wr   = is_write_q;
            bus.mem_addr = beat_q ? (addr_q + ADDR_WIDTH'(4)) : addr_q;
            if (is_write_q) begin
              bus.mem_wstrb = beat_q ? strb_hi : strb_lo;
              bus.mem_wdata = beat_q ? (wdata_q >> hi_shamt) : (wdata_q << lo_shamt);
            end
          end
        end
        ST_DONE: begin
          bus.bus_stbuf_read_ack  = !is_write_q;
          bus.bus_stbuf_write_ack = is_write_q;
        end
        default: ;
      endcase
    end
  end
endmodule
